// File: rtl/trigger_pkg.sv
// Shared definitions for the sequential LUT trigger: config word layout,
// LUT geometry and the load-sequencer state type.
package trigger_pkg;

  localparam int unsigned CFG_COUNT_LSB = 0;
  localparam int unsigned CFG_COUNT_MSB = 15;
  localparam int unsigned CFG_LEVEL_LSB = 16;
  localparam int unsigned CFG_LEVEL_W   = 4;
  localparam int unsigned CFG_START_BIT = 27;

  localparam int unsigned LUT_DEPTH = 16;
  localparam int unsigned NIBBLE    = 4;

  typedef enum logic {
    SEQ_IDLE,
    SEQ_LOAD
  } seq_state_e;

endpackage

// File: rtl/trigger_stage_lut.sv
// One trigger stage: WIDTH/4 16x1 match LUTs, registered hit, optional
// occurrence counter and the fired/match logic.
// Optional feature macro: TRIGGER_MATCHCOUNT_EN (per-stage occurrence counter).
module trigger_stage_lut
  import trigger_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LVL_W = 3
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 wrenb,
  input  logic [NIBBLE-1:0]                    wraddr,
  input  logic [WIDTH/NIBBLE-1:0]              din,
  input  logic                                 load_done,
  input  logic                                 cfg_wr,
`ifdef TRIGGER_MATCHCOUNT_EN
  input  logic [CFG_COUNT_MSB-CFG_COUNT_LSB:0] cfg_count,
`endif
  input  logic [CFG_LEVEL_W-1:0]               cfg_level,
  input  logic                                 cfg_start,
  input  logic                                 valid_in,
  input  logic [WIDTH-1:0]                     data_in,
  input  logic                                 armed,
  input  logic                                 arm,
  input  logic [LVL_W-1:0]                     level,
  output logic                                 match,
  output logic                                 start
);

  localparam int unsigned NLUT = WIDTH / NIBBLE;

  logic [LUT_DEPTH-1:0]   lut [NLUT];
  logic                   lut_hit;
  logic                   hit_q;
  logic                   loaded;
  logic                   fired;
  logic                   eligible;
  logic [CFG_LEVEL_W-1:0] level_q;
  logic                   start_q;

  // LUT write port; contents are deliberately not reset
  always_ff @(posedge clock) begin
    if (wrenb) begin
      for (int unsigned k = 0; k < NLUT; k++) begin
        lut[k][wraddr] <= din[k];
      end
    end
  end

  // AND of all LUT lookups addressed by the sample nibbles
  always_comb begin
    lut_hit = 1'b1;
    for (int unsigned k = 0; k < NLUT; k++) begin
      lut_hit = lut_hit & lut[k][data_in[k*NIBBLE +: NIBBLE]];
    end
  end

  // A hit arriving while arm is asserted is discarded
  assign eligible = armed & ~arm & loaded & ~fired &
                    (5'(level_q) == 5'(level));
  assign start    = start_q;

`ifdef TRIGGER_MATCHCOUNT_EN
  logic [CFG_COUNT_MSB-CFG_COUNT_LSB:0] count_q;
  logic [CFG_COUNT_MSB-CFG_COUNT_LSB:0] occ_q;

  assign match = eligible & hit_q & (occ_q == count_q);

  // Occurrence counter and its compare value
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      occ_q   <= '0;
    end else begin
      if (cfg_wr) count_q <= cfg_count;
      if (arm) occ_q <= '0;
      else if (eligible && hit_q && !match) occ_q <= occ_q + 16'd1;
    end
  end
`else
  assign match = eligible & hit_q;
`endif

  // Stage config, loaded flag, registered hit and fired latch
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= '0;
      start_q <= 1'b0;
      loaded  <= 1'b0;
      hit_q   <= 1'b0;
      fired   <= 1'b0;
    end else begin
      if (cfg_wr) begin
        level_q <= cfg_level;
        start_q <= cfg_start;
      end
      if (load_done) loaded <= 1'b1;
      hit_q <= valid_in & lut_hit;
      if (arm) fired <= 1'b0;
      else if (match) fired <= 1'b1;
    end
  end

endmodule

// File: rtl/trigger_lut_seq.sv
// Multi-stage sequential trigger for the logic-analyser capture path.
// Holds the shared mask/value registers, the serial LUT load sequencer,
// and the level/capture/run state. Stage logic lives in trigger_stage_lut.
// Optional feature macro: TRIGGER_MATCHCOUNT_EN (per-stage occurrence counter).
module trigger_lut_seq
  import trigger_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        valid_in,
  input  logic [WIDTH-1:0]            data_in,
  input  logic [STAGES-1:0]           wr_mask,
  input  logic [STAGES-1:0]           wr_value,
  input  logic [STAGES-1:0]           wr_config,
  input  logic [WIDTH-1:0]            config_data,
  input  logic                        arm,
  output logic                        capture,
  output logic                        run,
  output logic [$clog2(STAGES+1)-1:0] level,
  output logic                        busy
);

  localparam int unsigned LVL_W = $clog2(STAGES + 1);
  localparam int unsigned NLUT  = WIDTH / NIBBLE;
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(STAGES);

  seq_state_e        state;
  logic [WIDTH-1:0]  mask_q, value_q;
  logic [WIDTH-1:0]  burst_mask, burst_value;
  logic [STAGES-1:0] pending, active, req;
  logic [NIBBLE-1:0] wrcount, wraddr;
  logic              last, do_start;
  logic [NLUT-1:0]   lut_din;
  logic [STAGES-1:0] match_v, start_v;

  logic [CFG_LEVEL_W-1:0] cfg_level;
  logic                   cfg_start;

  assign cfg_level = CFG_LEVEL_W'(config_data >> CFG_LEVEL_LSB);
  assign cfg_start = 1'(config_data >> CFG_START_BIT);
`ifdef TRIGGER_MATCHCOUNT_EN
  logic [CFG_COUNT_MSB-CFG_COUNT_LSB:0] cfg_count;
  assign cfg_count = 16'(config_data >> CFG_COUNT_LSB);
`endif

  assign req      = pending | wr_value;
  assign last     = (state == SEQ_LOAD) && (wrcount == 4'hF);
  assign do_start = ((state == SEQ_IDLE) || last) && (|req);
  assign wraddr   = ~wrcount;

  // Shared mask/value registers written by software
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mask_q  <= '0;
      value_q <= '0;
    end else begin
      if (|wr_mask)  mask_q  <= config_data;
      if (|wr_value) value_q <= config_data;
    end
  end

  // Load sequencer; each burst snapshots mask/value so later writes queue cleanly
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= SEQ_IDLE;
      busy        <= 1'b0;
      pending     <= '0;
      active      <= '0;
      wrcount     <= '0;
      burst_mask  <= '0;
      burst_value <= '0;
    end else if (do_start) begin
      state       <= SEQ_LOAD;
      busy        <= 1'b1;
      active      <= req;
      pending     <= '0;
      wrcount     <= '0;
      burst_mask  <= (|wr_mask)  ? config_data : mask_q;
      burst_value <= (|wr_value) ? config_data : value_q;
    end else begin
      pending <= req;
      if (state == SEQ_LOAD) begin
        if (last) begin
          state  <= SEQ_IDLE;
          busy   <= 1'b0;
          active <= '0;
        end else begin
          wrcount <= wrcount + 4'd1;
        end
      end
    end
  end

  // LUT data generator: bit k is the nibble-k match result at the current address
  always_comb begin
    lut_din = '0;
    for (int unsigned k = 0; k < NLUT; k++) begin
      lut_din[k] = ~|((wraddr ^ burst_value[k*NIBBLE +: NIBBLE]) &
                      burst_mask[k*NIBBLE +: NIBBLE]);
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    trigger_stage_lut #(
      .WIDTH (WIDTH),
      .LVL_W (LVL_W)
    ) u_stage (
      .clock     (clock),
      .reset_n   (reset_n),
      .wrenb     (busy & active[s]),
      .wraddr    (wraddr),
      .din       (lut_din),
      .load_done (last & active[s]),
      .cfg_wr    (wr_config[s]),
`ifdef TRIGGER_MATCHCOUNT_EN
      .cfg_count (cfg_count),
`endif
      .cfg_level (cfg_level),
      .cfg_start (cfg_start),
      .valid_in  (valid_in),
      .data_in   (data_in),
      .armed     (capture),
      .arm       (arm),
      .level     (level),
      .match     (match_v[s]),
      .start     (start_v[s])
    );
  end

  // Capture/run/level; several simultaneous matches advance level by one
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      capture <= 1'b0;
      run     <= 1'b0;
      level   <= '0;
    end else if (arm) begin
      capture <= 1'b1;
      run     <= 1'b0;
      level   <= '0;
    end else begin
      if (|(match_v & start_v)) run <= 1'b1;
      if ((|match_v) && (level != LVL_MAX)) level <= level + LVL_W'(1);
    end
  end

endmodule

// File: tb/tb_trigger_lut_seq.sv
// Self-checking bench for trigger_lut_seq with a behavioural trigger model.
module tb_trigger_lut_seq;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned STAGES = 4;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              valid_in;
  logic [WIDTH-1:0]  data_in;
  logic [STAGES-1:0] wr_mask, wr_value, wr_config;
  logic [WIDTH-1:0]  config_data;
  logic              arm;
  logic              capture, run, busy;
  logic [2:0]        level;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  trigger_lut_seq #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .valid_in    (valid_in),
    .data_in     (data_in),
    .wr_mask     (wr_mask),
    .wr_value    (wr_value),
    .wr_config   (wr_config),
    .config_data (config_data),
    .arm         (arm),
    .capture     (capture),
    .run         (run),
    .level       (level),
    .busy        (busy)
  );

  // Behavioural model state
  logic [31:0] m_mask [STAGES];
  logic [31:0] m_val  [STAGES];
  int          m_need [STAGES];
  int          m_lvl  [STAGES];
  bit          m_st   [STAGES];
  bit          m_loaded [STAGES];
  bit          m_fired  [STAGES];
  bit          m_hit    [STAGES];
  int          m_occ    [STAGES];
  bit          m_cap, m_run;
  int          m_level;

  task automatic model_reset();
    for (int s = 0; s < STAGES; s++) begin
      m_mask[s] = '0; m_val[s] = '0; m_need[s] = 0; m_lvl[s] = 0; m_st[s] = 0;
      m_loaded[s] = 0; m_fired[s] = 0; m_hit[s] = 0; m_occ[s] = 0;
    end
    m_cap = 0; m_run = 0; m_level = 0;
  endtask

  // One clock cycle of stimulus plus the model's view of that edge
  task automatic step(input bit v, input logic [31:0] d, input bit a);
    bit any;
    valid_in = v; data_in = d; arm = a;
    @(posedge clock);
    if (a) begin
      m_cap = 1; m_run = 0; m_level = 0;
      for (int s = 0; s < STAGES; s++) begin m_fired[s] = 0; m_occ[s] = 0; end
    end else if (m_cap) begin
      any = 0;
      for (int s = 0; s < STAGES; s++) begin
        if (m_hit[s] && m_loaded[s] && !m_fired[s] && m_lvl[s] == m_level) begin
          if (m_occ[s] >= m_need[s]) begin
            m_fired[s] = 1; any = 1;
            if (m_st[s]) m_run = 1;
          end else begin
            m_occ[s]++;
          end
        end
      end
      if (any && m_level < STAGES) m_level++;
    end
    for (int s = 0; s < STAGES; s++)
      m_hit[s] = v && m_loaded[s] && (((d ^ m_val[s]) & m_mask[s]) == 32'd0);
    @(negedge clock);
  endtask

  task automatic write_cfg(input int s, input logic [15:0] cnt,
                           input logic [3:0] lvl, input bit st);
    config_data = {4'($urandom), st, 7'($urandom), lvl, cnt};
    wr_config = 4'(1 << s);
    step(0, '0, 0);
    wr_config = '0;
`ifdef TRIGGER_MATCHCOUNT_EN
    m_need[s] = int'(cnt);
`else
    m_need[s] = 0;
`endif
    m_lvl[s] = int'(lvl); m_st[s] = st;
  endtask

  task automatic load_stage(input int s, input logic [31:0] mk, input logic [31:0] vl);
    int n;
    config_data = mk; wr_mask = 4'(1 << s); step(0, '0, 0); wr_mask = '0;
    config_data = vl; wr_value = 4'(1 << s); step(0, '0, 0); wr_value = '0;
    m_mask[s] = mk; m_val[s] = vl;
    n = 0;
    while (busy === 1'b1 && n < 40) begin n++; step(0, '0, 0); end
    checks++;
    if (n != 16) begin
      errors++; $display("FAIL load_busy_len stage %0d got %0d cycles exp 16", s, n);
    end
    m_loaded[s] = 1;
  endtask

  task automatic apply_reset();
    reset_n = 0; valid_in = 0; data_in = '0; arm = 0;
    wr_mask = '0; wr_value = '0; wr_config = '0; config_data = '0;
    @(negedge clock); @(negedge clock);
    model_reset();
    reset_n = 1;
    step(0, '0, 0);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (capture !== 1'b0) begin errors++; $display("FAIL reset_capture got %b exp 0", capture); end
    checks++; if (run !== 1'b0) begin errors++; $display("FAIL reset_run got %b exp 0", run); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
  endtask

  task automatic test_basic_match();
    logic [31:0] d;
    write_cfg(0, 16'd0, 4'd0, 1);
    for (int s = 1; s < STAGES; s++) write_cfg(s, 16'd0, 4'd15, 0);
    load_stage(0, 32'h0000FFFF, 32'h00001234);
    step(0, '0, 1);
    checks++; if (capture !== 1'b1) begin errors++; $display("FAIL arm_capture got %b exp 1", capture); end
    step(1, 32'hABCD1235, 0); step(0, '0, 0); step(0, '0, 0);
    checks++; if (run !== 1'b0) begin errors++; $display("FAIL nomatch_run got %b exp 0", run); end
    step(1, 32'hABCD1234, 0);
    checks++; if (run !== 1'b0) begin errors++; $display("FAIL match_early_run got %b exp 0", run); end
    step(0, '0, 0);
    checks++; if (run !== 1'b1) begin errors++; $display("FAIL match_run got %b exp 1", run); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL match_level got %0d exp 1", level); end
    // randomized samples against the model, with occasional re-arm
    for (int i = 0; i < 80; i++) begin
      d = ($urandom_range(0, 1) == 1) ? {16'($urandom), 16'h1234} : $urandom;
      step(1'($urandom), d, $urandom_range(0, 15) == 0);
      checks++;
      if (run !== m_run || level !== 3'(m_level) || capture !== m_cap) begin
        errors++;
        $display("FAIL rand_basic cyc %0d got run=%b lvl=%0d cap=%b exp run=%b lvl=%0d cap=%b",
                 i, run, level, capture, m_run, m_level, m_cap);
      end
    end
  endtask

  task automatic test_sequence();
    write_cfg(0, 16'd0, 4'd0, 0);
    write_cfg(1, 16'd0, 4'd1, 1);
    load_stage(0, 32'h000000FF, 32'h000000A5);
    load_stage(1, 32'h0000FF00, 32'h00003C00);
    step(0, '0, 1);
    step(1, 32'h777711A5, 0); step(0, '0, 0);
    checks++;
    if (level !== 3'd1 || run !== 1'b0 || m_level != 1) begin
      errors++; $display("FAIL seq_a got lvl=%0d run=%b exp lvl=1 run=0", level, run);
    end
    step(1, 32'h12343C00, 0); step(0, '0, 0);
    checks++;
    if (level !== 3'd2 || run !== 1'b1 || !m_run) begin
      errors++; $display("FAIL seq_b got lvl=%0d run=%b exp lvl=2 run=1", level, run);
    end
    step(0, '0, 1);
    step(1, 32'h12343C00, 0); step(0, '0, 0);
    step(1, 32'h777711A5, 0); step(0, '0, 0); step(0, '0, 0);
    checks++;
    if (level !== 3'd1 || run !== 1'b0 || m_run) begin
      errors++; $display("FAIL seq_ba got lvl=%0d run=%b exp lvl=1 run=0", level, run);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [31:0] d;
    write_cfg(0, 16'd0, 4'd15, 0);
    write_cfg(1, 16'd0, 4'd15, 0);
    config_data = 32'h00FF00FF; wr_mask = 4'b0100; step(0, '0, 0); wr_mask = '0;
    config_data = 32'h00110022; wr_value = 4'b0100; step(0, '0, 0); wr_value = '0;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      if (busy !== 1'b1) break;
      n++;
      if (i == 5) begin config_data = 32'h00330044; wr_value = 4'b1000; end
      step(0, '0, 0);
      wr_value = '0;
    end
    m_mask[2] = 32'h00FF00FF; m_val[2] = 32'h00110022; m_loaded[2] = 1;
    m_mask[3] = 32'h00FF00FF; m_val[3] = 32'h00330044; m_loaded[3] = 1;
    checks++;
    if (n != 32) begin errors++; $display("FAIL b2b_busy_len got %0d exp 32", n); end
    write_cfg(2, 16'd0, 4'd0, 0);
    write_cfg(3, 16'd0, 4'd1, 1);
    step(0, '0, 1);
    step(1, 32'hAA33BB44, 0); step(0, '0, 0);
    checks++;
    if (level !== 3'd0 || run !== 1'b0) begin
      errors++; $display("FAIL b2b_early got lvl=%0d run=%b exp lvl=0 run=0", level, run);
    end
    step(1, 32'hAA11BB22, 0); step(0, '0, 0);
    checks++;
    if (level !== 3'd1 || run !== 1'b0) begin
      errors++; $display("FAIL b2b_stage2 got lvl=%0d run=%b exp lvl=1 run=0", level, run);
    end
    step(1, 32'h5533CC44, 0); step(0, '0, 0);
    checks++;
    if (level !== 3'd2 || run !== 1'b1) begin
      errors++; $display("FAIL b2b_stage3 got lvl=%0d run=%b exp lvl=2 run=1", level, run);
    end
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 2))
        0: d = {8'($urandom), 8'h11, 8'($urandom), 8'h22};
        1: d = {8'($urandom), 8'h33, 8'($urandom), 8'h44};
        default: d = $urandom;
      endcase
      step(1'($urandom), d, $urandom_range(0, 11) == 0);
      checks++;
      if (run !== m_run || level !== 3'(m_level)) begin
        errors++;
        $display("FAIL rand_b2b cyc %0d got run=%b lvl=%0d exp run=%b lvl=%0d",
                 i, run, level, m_run, m_level);
      end
    end
  endtask

  task automatic test_same_level();
    write_cfg(0, 16'd0, 4'd0, 0);
    write_cfg(1, 16'd0, 4'd0, 0);
    write_cfg(2, 16'd0, 4'd15, 0);
    write_cfg(3, 16'd0, 4'd15, 0);
    step(0, '0, 1);
    step(1, 32'h00003CA5, 0); step(0, '0, 0); step(0, '0, 0);
    checks++;
    if (level !== 3'd1 || m_level != 1 || run !== 1'b0) begin
      errors++; $display("FAIL same_level got lvl=%0d run=%b exp lvl=1 run=0", level, run);
    end
  endtask

`ifdef TRIGGER_MATCHCOUNT_EN
  task automatic test_matchcount();
    write_cfg(0, 16'd3, 4'd0, 1);
    write_cfg(1, 16'd0, 4'd15, 0);
    write_cfg(2, 16'd0, 4'd15, 0);
    write_cfg(3, 16'd0, 4'd15, 0);
    step(0, '0, 1);
    step(1, 32'h000000A5, 0); step(0, 32'h000000A5, 0);
    step(1, 32'h111111A5, 0); step(0, 32'h000000A5, 0);
    step(1, 32'h222222A5, 0); step(1, 32'h00000000, 0); step(0, '0, 0); step(0, '0, 0);
    checks++;
    if (run !== 1'b0 || m_run) begin errors++; $display("FAIL mc_three got run=%b exp 0", run); end
    step(1, 32'h333333A5, 0);
    step(0, '0, 0);
    checks++;
    if (run !== 1'b1 || !m_run) begin errors++; $display("FAIL mc_fourth got run=%b exp 1", run); end
  endtask
`endif

  task automatic test_reset_mid_load();
    config_data = 32'h000000FF; wr_mask = 4'b0001; step(0, '0, 0); wr_mask = '0;
    config_data = 32'h00000011; wr_value = 4'b0001; step(0, '0, 0); wr_value = '0;
    for (int i = 0; i < 5; i++) step(0, '0, 0);
    reset_n = 0;
    #1;
    checks++;
    if (capture !== 1'b0 || run !== 1'b0 || level !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midload_reset got cap=%b run=%b lvl=%0d busy=%b exp all 0",
               capture, run, level, busy);
    end
    @(negedge clock);
    model_reset();
    reset_n = 1;
    step(0, '0, 0);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midload_busy got %b exp 0", busy); end
    write_cfg(0, 16'd0, 4'd0, 1);
    step(0, '0, 1);
    for (int i = 0; i < 30; i++) begin
      step(1, (i % 2 == 0) ? 32'h00000011 : $urandom, 0);
      checks++;
      if (run !== 1'b0 || level !== 3'd0 || m_run) begin
        errors++; $display("FAIL unloaded_fire cyc %0d got run=%b lvl=%0d exp 0 0", i, run, level);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_basic_match();
    test_sequence();
    test_back_to_back();
    test_same_level();
`ifdef TRIGGER_MATCHCOUNT_EN
    test_matchcount();
`endif
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
